// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: FSM encoding, default width and
// the HI/LO field positions inside the packed {remainder, quotient} result.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  // LO holds the quotient, HI holds the remainder.
  localparam int DIV_LO_LSB = 0;
  localparam int DIV_LO_MSB = DIV_WIDTH - 1;
  localparam int DIV_HI_LSB = DIV_WIDTH;
  localparam int DIV_HI_MSB = 2 * DIV_WIDTH - 1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_DIVZ = 2'd1,
    DIV_BUSY = 2'd2,
    DIV_DONE = 2'd3
  } divState_t;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic             dividendBit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic             quoBit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // remIn < divisor, so the shifted value fits in WIDTH+1 bits and a set MSB of
  // the difference means the subtraction went negative.
  always_comb begin
    shifted = {remIn, dividendBit};
    diff    = shifted - {1'b0, divisor};
    quoBit  = ~diff[WIDTH];
    remOut  = quoBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, with hazard-unit stall output,
// exception annul, and {HI=remainder, LO=quotient} result.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_div_o,
  output divState_t          dbgState
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  divState_t        state, nextState;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divisorReg;
  logic             negQuo, negRem;
  logic [2*WIDTH-1:0] resultReg;

  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH-1:0] stepRem;
  logic             stepQuo;
  logic [WIDTH-1:0] finalQuo, fixQuo, fixRem;
  logic             lastIter;

  // quoReg starts as the dividend; its MSB feeds each step while quotient bits
  // shift in at the bottom.
  div_step #(.WIDTH(WIDTH)) uStep (
    .remIn      (remReg),
    .dividendBit(quoReg[WIDTH-1]),
    .divisor    (divisorReg),
    .remOut     (stepRem),
    .quoBit     (stepQuo)
  );

  always_comb begin
    absA     = (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
    absB     = (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;
    lastIter = (counter == LAST_ITER);
    finalQuo = {quoReg[WIDTH-2:0], stepQuo};
    fixQuo   = negQuo ? -finalQuo : finalQuo;
    fixRem   = negRem ? -stepRem : stepRem;
  end

  always_comb begin
    nextState = state;
    case (state)
      DIV_IDLE: if (start_i) nextState = (opb_i == '0) ? DIV_DIVZ : DIV_BUSY;
      DIV_DIVZ: nextState = DIV_DONE;
      DIV_BUSY: if (lastIter) nextState = DIV_DONE;
      DIV_DONE: nextState = DIV_IDLE;
      default:  nextState = DIV_IDLE;
    endcase
    if (annul_i) nextState = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DIV_IDLE;
      counter    <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      negQuo     <= 1'b0;
      negRem     <= 1'b0;
      resultReg  <= '0;
    end else begin
      state <= nextState;
      if (!annul_i) begin
        case (state)
          DIV_IDLE: begin
            if (start_i && opb_i != '0) begin
              remReg     <= '0;
              quoReg     <= absA;
              divisorReg <= absB;
              negQuo     <= signed_i && (opa_i[WIDTH-1] != opb_i[WIDTH-1]);
              negRem     <= signed_i && opa_i[WIDTH-1];
              counter    <= '0;
            end
          end
          DIV_DIVZ: resultReg <= '0;
          DIV_BUSY: begin
            remReg  <= stepRem;
            quoReg  <= finalQuo;
            counter <= counter + CNT_W'(1);
            // The sign fix-up is folded into the final iteration so the result
            // register is already valid in the DONE cycle.
            if (lastIter) resultReg <= {fixRem, fixQuo};
          end
          default: ;
        endcase
      end
    end
  end

  assign result_o    = resultReg;
  assign ready_o     = (state == DIV_DONE) && !annul_i;
  assign stall_div_o = start_i && !ready_o;
  assign dbgState    = state;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed table of DIV/DIVU vectors, annul/reset/back-to-back
// sequences, and randomized operations against a plain-arithmetic reference model.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, annul_i;
  logic [31:0] opa_i, opb_i;
  logic [63:0] result_o;
  logic        ready_o, stall_div_o;
  divState_t   dbgState;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    int          expLat;
  } vec_t;

  vec_t vecs[$];
  logic [63:0] exp_q[$];

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opa_i      (opa_i),
    .opb_i      (opb_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stall_div_o(stall_div_o),
    .dbgState   (dbgState)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: 64-bit arithmetic so the most-negative / -1 case cannot trap.
  function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Runs one operation from the cycle start_i is first presented. Latency k counts
  // cycles from that sampling cycle; stall is counted on every sampled cycle.
  task automatic doOp(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                      input bit holdAfter, input bit scramble,
                      output logic [63:0] res, output int lat, output int stallCnt);
    @(negedge clk);
    start_i  = 1'b1;
    signed_i = sgn;
    opa_i    = a;
    opb_i    = b;
    lat      = -1;
    stallCnt = 0;
    res      = '0;
    for (int k = 0; k <= 60; k++) begin
      #1;
      if (stall_div_o) stallCnt++;
      if (ready_o) begin
        lat = k;
        res = result_o;
        break;
      end
      @(negedge clk);
      if (scramble) begin
        opa_i    = $urandom;
        opb_i    = $urandom;
        signed_i = $urandom_range(0, 1);
      end
    end
    if (!holdAfter) start_i = 1'b0;
  endtask

  logic [63:0] res, res2, prevRes, expRes;
  int lat, stallCnt, readySeen;

  initial begin
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opa_i = '0; opb_i = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_result", result_o, 64'd0);
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_stall", {63'd0, stall_div_o}, 64'd0);
    check("reset_state", {62'd0, dbgState}, {62'd0, DIV_IDLE});
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         33});
    vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFF2,  33});
    vecs.push_back('{1'b1, 32'd100,        32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFF2,  33});
    vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33});
    vecs.push_back('{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33});
    vecs.push_back('{1'b0, 32'd12345,      32'd0,          32'd0,          32'd0,          2});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd0,          32'd0,          32'd0,          2});
    vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  33});
    vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FF9C,  32'd7,          32'd0,          33});
    vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd3,          33});
    vecs.push_back('{1'b0, 32'd9,          32'd3,          32'd0,          32'd3,          33});

    foreach (vecs[i]) begin
      doOp(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0, 1'b0, res, lat, stallCnt);
      check($sformatf("vec%0d_hi", i), {32'd0, res[DIV_HI_MSB:DIV_HI_LSB]}, {32'd0, vecs[i].expHi});
      check($sformatf("vec%0d_lo", i), {32'd0, res[DIV_LO_MSB:DIV_LO_LSB]}, {32'd0, vecs[i].expLo});
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].expLat));
      check($sformatf("vec%0d_stall", i), 64'(stallCnt), 64'(vecs[i].expLat));
    end

    // Annul at iteration 10: start sampled, then BUSY iterations 0..10.
    prevRes = result_o;
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd1000; opb_i = 32'd3;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    #1;
    check("annul_state", {62'd0, dbgState}, {62'd0, DIV_IDLE});
    check("annul_ready", {63'd0, ready_o}, 64'd0);
    check("annul_result_kept", result_o, prevRes);
    readySeen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_o) readySeen++;
    end
    check("annul_no_strobe", 64'(readySeen), 64'd0);
    doOp(1'b0, 32'd9, 32'd3, 1'b0, 1'b0, res, lat, stallCnt);
    check("post_annul_result", res, {32'd0, 32'd3});
    check("post_annul_lat", 64'(lat), 64'd33);

    // Reset mid-BUSY discards everything.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b1; opa_i = 32'hFFFF_0000; opb_i = 32'd5;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_result", result_o, 64'd0);
    check("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    check("rst_mid_state", {62'd0, dbgState}, {62'd0, DIV_IDLE});
    rst = 1'b0;

    // Back-to-back: start held through the strobe, new operands in the next cycle.
    doOp(1'b0, 32'd100, 32'd7, 1'b1, 1'b0, res, lat, stallCnt);
    doOp(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, res2, lat, stallCnt);
    check("b2b_first", res, {32'd2, 32'd14});
    check("b2b_second", res2, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    check("b2b_second_lat", 64'(lat), 64'd33);

    // Randomized operations with operands scrambled while busy.
    for (int n = 0; n < 150; n++) begin
      logic        sgn;
      logic [31:0] a, b;
      sgn = $urandom_range(0, 1);
      a   = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 16);
        3:       b = 32'd1 << $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      exp_q.push_back(refDiv(sgn, a, b));
      doOp(sgn, a, b, 1'b0, 1'b1, res, lat, stallCnt);
      expRes = exp_q.pop_front();
      check($sformatf("rand%0d_result", n), res, expRes);
      check($sformatf("rand%0d_lat", n), 64'(lat), (b == 32'd0) ? 64'd2 : 64'd33);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
